// File: rtl/udp_rx_frame_parser.sv
// udp_rx_frame_parser
//   Accepts UDP header + payload stream from the receive wrapper, filters by
//   source IP, strips the leading sequence byte, checks the declared length
//   and forwards data bytes as an AXI-stream frame through one output register.
//
//   Optional build macro: UDP_RX_SEQ_CHECK_EN enables sequence continuity
//   checking (err_seq). Without it err_seq is tied low.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   s_hdr_valid/s_hdr_ready          header handshake (ready only in IDLE)
//   s_source_ip, s_length            header fields (length = data bytes)
//   s_axis_t{valid,ready,data,last,user}  payload input stream
//   m_axis_t{valid,ready,data,last,user}  data output stream
//   seq_out                          sequence byte of last accepted frame
//   frame_ok, err_ip, err_len, err_seq   one-cycle status pulses
//   frame_cnt                        count of frame_ok pulses (wraps)
module udp_rx_frame_parser #(
  parameter logic [31:0] EXPECTED_IP = 32'hC0A80180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [31:0] s_source_ip,
  input  logic [9:0]  s_length,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [7:0]  seq_out,
  output logic        frame_ok,
  output logic        err_ip,
  output logic        err_len,
  output logic        err_seq,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SEQ, DATA, DROP} state_t;

  state_t      state_q;
  logic [9:0]  len_q;
  logic [9:0]  cnt_q;
  logic        tuser_q;     // sticky OR of s_axis_tuser across the frame
  logic        pend_len_q;  // err_len owed when the DROP tail ends
  logic        m_valid_q;
  logic [7:0]  m_data_q;
  logic        m_last_q;
  logic        m_user_q;
  logic [7:0]  seq_q;
  logic        ok_q;
  logic        ip_err_q;
  logic        len_err_q;
  logic [15:0] frame_cnt_q;

  logic        s_beat;
  logic        tuser_acc;
  logic [9:0]  cnt_inc;

  assign s_hdr_ready = (state_q == IDLE);

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state_q)
      IDLE:    s_axis_tready = 1'b0;
      SEQ:     s_axis_tready = 1'b1;
      DATA:    s_axis_tready = !m_valid_q || m_axis_tready;
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign s_beat    = s_axis_tvalid && s_axis_tready;
  assign tuser_acc = tuser_q | s_axis_tuser;
  assign cnt_inc   = cnt_q + 10'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      tuser_q     <= 1'b0;
      pend_len_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      seq_q       <= '0;
      ok_q        <= 1'b0;
      ip_err_q    <= 1'b0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      ok_q      <= 1'b0;
      ip_err_q  <= 1'b0;
      len_err_q <= 1'b0;
      // Output beat retires on tready; a new load in DATA overrides this.
      if (m_axis_tready) m_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (s_hdr_valid) begin
            len_q      <= s_length;
            cnt_q      <= '0;
            tuser_q    <= 1'b0;
            pend_len_q <= 1'b0;
            if ((EXPECTED_IP != '0) && (s_source_ip != EXPECTED_IP)) begin
              ip_err_q <= 1'b1;
              state_q  <= DROP;
            end else begin
              state_q  <= SEQ;
            end
          end
        end
        SEQ: begin
          if (s_beat) begin
            seq_q   <= s_axis_tdata;
            tuser_q <= tuser_acc;
            if (s_axis_tlast) begin
              state_q <= IDLE;
              if (len_q == '0) begin
                if (!tuser_acc) begin
                  ok_q        <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                end
              end else begin
                len_err_q <= 1'b1;
              end
            end else if (len_q == '0) begin
              pend_len_q <= 1'b1;
              state_q    <= DROP;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (s_beat) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_tdata;
            cnt_q     <= cnt_inc;
            tuser_q   <= tuser_acc;
            if (cnt_inc == len_q) begin
              m_last_q <= 1'b1;
              m_user_q <= tuser_acc;
              if (s_axis_tlast) begin
                state_q <= IDLE;
                if (!tuser_acc) begin
                  ok_q        <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
                end
              end else begin
                // Declared length reached early: close the output frame now,
                // swallow the surplus and report the error on its tlast.
                pend_len_q <= 1'b1;
                state_q    <= DROP;
              end
            end else if (s_axis_tlast) begin
              m_last_q  <= 1'b1;
              m_user_q  <= 1'b1;
              len_err_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              m_last_q <= 1'b0;
              m_user_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (s_beat && s_axis_tlast) begin
            len_err_q <= pend_len_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UDP_RX_SEQ_CHECK_EN
  logic first_q;
  logic seq_err_q;

  // Expected value is seq_q + 1; seq_q is reloaded with every received
  // sequence byte, which also gives the resync on mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= 1'b0;
      if ((state_q == SEQ) && s_beat) begin
        first_q   <= 1'b0;
        seq_err_q <= !first_q && (s_axis_tdata != (seq_q + 8'd1));
      end
    end
  end

  assign err_seq = seq_err_q;
`else
  assign err_seq = 1'b0;
`endif

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign seq_out       = seq_q;
  assign frame_ok      = ok_q;
  assign err_ip        = ip_err_q;
  assign err_len       = len_err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_udp_rx_frame_parser.sv
// Testbench for udp_rx_frame_parser: directed frames, scoreboard of expected
// output beats, pulse counters checked per frame.
module tb_udp_rx_frame_parser;
  localparam logic [31:0] EXP_IP = 32'hC0A80180;
`ifdef UDP_RX_SEQ_CHECK_EN
  localparam int SEQ_ON = 1;
`else
  localparam int SEQ_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_hdr_valid = 1'b0;
  logic        s_hdr_ready;
  logic [31:0] s_source_ip = '0;
  logic [9:0]  s_length = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [7:0]  seq_out;
  logic        frame_ok, err_ip, err_len, err_seq;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  udp_rx_frame_parser #(.EXPECTED_IP(EXP_IP)) dut (
    .clk(clk), .rst(rst),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_source_ip(s_source_ip), .s_length(s_length),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .seq_out(seq_out), .frame_ok(frame_ok), .err_ip(err_ip),
    .err_len(err_len), .err_seq(err_seq), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_beats = 0;
  int c_ok = 0, c_ip = 0, c_len = 0, c_seq = 0;
  int s_ok = 0, s_ip = 0, s_len = 0, s_seq = 0;
  logic [9:0] sb[$];  // {data, last, user}
  bit toggle_mode = 1'b0;

  always @(negedge clk) m_axis_tready = toggle_mode ? ~m_axis_tready : 1'b1;

  // Output monitor: beat transfers and pulse counting, mid-cycle.
  always @(negedge clk) begin
    logic [9:0] exp_beat;
    #2;
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed %02h/%0b/%0b required none",
                 m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          n_cmp++;
          assert ({m_axis_tdata, m_axis_tlast, m_axis_tuser} === exp_beat) else begin
            n_fail++;
            $error("FAIL beat: observed %02h/%0b/%0b required %02h/%0b/%0b",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser,
                   exp_beat[9:2], exp_beat[1], exp_beat[0]);
          end
        end
      end
      if (frame_ok) c_ok++;
      if (err_ip)   c_ip++;
      if (err_len)  c_len++;
      if (err_seq)  c_seq++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulses(input string tag, input int ok, input int ip,
                               input int len, input int sq);
    chk({tag, "_frame_ok"}, c_ok - s_ok, ok);
    chk({tag, "_err_ip"},   c_ip - s_ip, ip);
    chk({tag, "_err_len"},  c_len - s_len, len);
    chk({tag, "_err_seq"},  c_seq - s_seq, sq);
    s_ok = c_ok; s_ip = c_ip; s_len = c_len; s_seq = c_seq;
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [9:0] len);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      s_hdr_valid = 1'b1; s_source_ip = ip; s_length = len;
      #1;
      if (s_hdr_ready) begin @(posedge clk); #1; done = 1'b1; end
    end
    s_hdr_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $error("FAIL hdr_timeout: observed no accept required accept");
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u;
      #1;
      if (s_axis_tready) begin @(posedge clk); #1; done = 1'b1; end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $error("FAIL byte_timeout: observed no accept required accept");
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_hdr_valid = 1'b0; s_axis_tvalid = 1'b0; toggle_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    sb.delete();
    s_ok = c_ok; s_ip = c_ip; s_len = c_len; s_seq = c_seq;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hdr_ready"},  s_hdr_ready, 1);
    chk({tag, "_s_tready"},   s_axis_tready, 0);
    chk({tag, "_m_out"},      {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 0);
    chk({tag, "_seq_out"},    seq_out, 0);
    chk({tag, "_frame_cnt"},  frame_cnt, 0);
    chk({tag, "_pulses"},     {frame_ok, err_ip, err_len, err_seq}, 0);
  endtask

  initial begin
    int beats0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("reset");

    // Good frame, length 4.
    sb.push_back({8'hA1, 2'b00}); sb.push_back({8'hA2, 2'b00});
    sb.push_back({8'hA3, 2'b00}); sb.push_back({8'hA4, 2'b10});
    send_hdr(EXP_IP, 10'd4);
    send_byte(8'h07, 0, 0);
    @(negedge clk); #1;
    chk("hdr_ready_busy", s_hdr_ready, 0);
    send_byte(8'hA1, 0, 0); send_byte(8'hA2, 0, 0);
    send_byte(8'hA3, 0, 0); send_byte(8'hA4, 1, 0);
    settle();
    expect_pulses("good", 1, 0, 0, 0);
    chk("good_seq_out", seq_out, 8'h07);
    chk("good_frame_cnt", frame_cnt, 1);

    // Wrong source IP: consumed and dropped.
    send_hdr(32'hC0A80105, 10'd3);
    send_byte(8'h55, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h02, 0, 0); send_byte(8'h03, 1, 0);
    settle();
    expect_pulses("badip", 0, 1, 0, 0);
    chk("badip_frame_cnt", frame_cnt, 1);
    chk("badip_seq_out", seq_out, 8'h07);

    // Too long: length 2, three data bytes.
    sb.push_back({8'hB1, 2'b00}); sb.push_back({8'hB2, 2'b10});
    send_hdr(EXP_IP, 10'd2);
    send_byte(8'h08, 0, 0); send_byte(8'hB1, 0, 0);
    send_byte(8'hB2, 0, 0); send_byte(8'hB3, 1, 0);
    settle();
    expect_pulses("long", 0, 0, 1, 0);
    chk("long_frame_cnt", frame_cnt, 1);

    // Too short: length 5, two data bytes.
    sb.push_back({8'hC1, 2'b00}); sb.push_back({8'hC2, 2'b11});
    send_hdr(EXP_IP, 10'd5);
    send_byte(8'h09, 0, 0); send_byte(8'hC1, 0, 0); send_byte(8'hC2, 1, 0);
    settle();
    expect_pulses("short", 0, 0, 1, 0);
    chk("short_seq_out", seq_out, 8'h09);

    // Sequence 10, 11, 13 after reset.
    do_reset();
    chk_reset_state("reset2");
    sb.push_back({8'hD0, 2'b10});
    send_hdr(EXP_IP, 10'd1); send_byte(8'h10, 0, 0); send_byte(8'hD0, 1, 0);
    sb.push_back({8'hD1, 2'b10});
    send_hdr(EXP_IP, 10'd1); send_byte(8'h11, 0, 0); send_byte(8'hD1, 1, 0);
    settle();
    expect_pulses("seq_10_11", 2, 0, 0, 0);
    sb.push_back({8'hD3, 2'b10});
    send_hdr(EXP_IP, 10'd1); send_byte(8'h13, 0, 0); send_byte(8'hD3, 1, 0);
    settle();
    expect_pulses("seq_13", 1, 0, 0, SEQ_ON);
    chk("seq_frame_cnt", frame_cnt, 3);
    chk("seq_seq_out", seq_out, 8'h13);

    // tuser on the sequence byte only: carried to the last beat, no frame_ok.
    sb.push_back({8'hE1, 2'b00}); sb.push_back({8'hE2, 2'b11});
    send_hdr(EXP_IP, 10'd2);
    send_byte(8'h14, 0, 1); send_byte(8'hE1, 0, 0); send_byte(8'hE2, 1, 0);
    settle();
    expect_pulses("tuser", 0, 0, 0, 0);

    // Length 0 with only the sequence byte: ok, no beats.
    send_hdr(EXP_IP, 10'd0); send_byte(8'h15, 1, 0);
    settle();
    expect_pulses("len0", 1, 0, 0, 0);
    chk("len0_frame_cnt", frame_cnt, 4);

    // Length 0 with a surplus byte: err_len on its tlast.
    send_hdr(EXP_IP, 10'd0); send_byte(8'h16, 0, 0); send_byte(8'hF1, 1, 0);
    settle();
    expect_pulses("len0x", 0, 0, 1, 0);
    chk("len0x_seq_out", seq_out, 8'h16);

    // Backpressure 1010... on a 16-byte frame, reset after 8 data bytes.
    beats0 = n_beats;
    toggle_mode = 1'b1;
    send_hdr(EXP_IP, 10'd16);
    send_byte(8'h17, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h30 + 8'(i);
      sb.push_back({d, 2'b00});
      send_byte(d, 0, 0);
    end
    do_reset();
    chk("bp_beats_before_reset", n_beats - beats0, 7);
    chk_reset_state("reset3");

    // Next frame parses cleanly.
    sb.push_back({8'h41, 2'b00}); sb.push_back({8'h42, 2'b00});
    sb.push_back({8'h43, 2'b10});
    send_hdr(EXP_IP, 10'd3);
    send_byte(8'h40, 0, 0); send_byte(8'h41, 0, 0);
    send_byte(8'h42, 0, 0); send_byte(8'h43, 1, 0);
    settle();
    expect_pulses("post", 1, 0, 0, 0);
    chk("post_frame_cnt", frame_cnt, 1);
    chk("post_seq_out", seq_out, 8'h40);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
